// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared DMSel encodings, FSM state type and alignment check
//               for the data-memory bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam int         EXT_ZERO = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } dm_state_e;

    // DMSel[1] set means word, whether the low bit is 0 or 1
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] addr);
        is_misaligned = ((sel[1:0] == SEL_HALF) && addr[0]) || (sel[1] && (addr != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_unit
// Description : Byte/half lane extraction with extension for loads, and
//               lane merge of partial store data into a full memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_dm_sel,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

        if (i_dm_sel[1]) begin
            o_load_data = i_word;
        end else if (i_dm_sel[1:0] == SEL_HALF) begin
            o_load_data = i_dm_sel[EXT_ZERO] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        end else begin
            o_load_data = i_dm_sel[EXT_ZERO] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        end

        o_store_word = i_word;
        if (i_dm_sel[1]) begin
            o_store_word = i_wdata;
        end else if (i_dm_sel[1:0] == SEL_HALF) begin
            if (i_addr[1]) o_store_word[31:16] = i_wdata[15:0];
            else           o_store_word[15:0]  = i_wdata[15:0];
        end else begin
            case (i_addr)
                2'd0: o_store_word[7:0]   = i_wdata[7:0];
                2'd1: o_store_word[15:8]  = i_wdata[7:0];
                2'd2: o_store_word[23:16] = i_wdata[7:0];
                2'd3: o_store_word[31:24] = i_wdata[7:0];
                default: o_store_word = i_word;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : dm_bus_initiator
// Description : Runs one CPU load/store over a word-only valid/ready bus,
//               with read-modify-write for partial stores and a wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_bus_initiator
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  DMSel,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] PC,
    output logic        stall,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic [31:0] trace_pc
);

    localparam int                c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    dm_state_e          r_state;
    logic               r_we;
    logic [2:0]         r_sel;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_pc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_req_valid;
    logic               r_mem_req_we;
    logic               r_cpu_done;
    logic               r_cpu_err;
    logic [31:0]        r_cpu_rdata;
    logic [31:0]        r_trace_pc;
    logic [31:0]        w_load_data;
    logic [31:0]        w_store_word;

    dm_lane_unit u_lane (
        .i_word       (mem_rsp_rdata),
        .i_addr       (r_addr[1:0]),
        .i_dm_sel     (r_sel),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_we            <= 1'b0;
            r_sel           <= 3'b000;
            r_addr          <= 32'h0;
            r_wdata         <= 32'h0;
            r_pc            <= 32'h0;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_cpu_done      <= 1'b0;
            r_cpu_err       <= 1'b0;
            r_cpu_rdata     <= 32'h0;
            r_trace_pc      <= 32'h0;
        end else begin
            r_cpu_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_sel   <= DMSel;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_pc    <= PC;
                        if (is_misaligned(DMSel, cpu_addr[1:0])) begin
                            r_cpu_err  <= 1'b1;
                            r_cpu_done <= 1'b1;
                            r_state    <= DONE;
                        end else if (cpu_we && DMSel[1]) begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_we    <= 1'b1;
                            r_state         <= WR_REQ;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_we    <= 1'b0;
                            r_state         <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // A response on the final wait cycle wins over the timeout
                    if (mem_rsp_valid) begin
                        if (r_we) begin
                            r_wdata         <= w_store_word;
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_we    <= 1'b1;
                            r_state         <= WR_REQ;
                        end else begin
                            r_cpu_rdata <= w_load_data;
                            r_cpu_done  <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cpu_err  <= 1'b1;
                        r_cpu_done <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_trace_pc <= r_pc;
                        r_cpu_done <= 1'b1;
                        r_state    <= DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cpu_err  <= 1'b1;
                        r_cpu_done <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_cpu_err <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall         = (cpu_req && (r_state == IDLE)) || ((r_state != IDLE) && (r_state != DONE));
    assign cpu_done      = r_cpu_done;
    assign cpu_err       = r_cpu_err;
    assign cpu_rdata     = r_cpu_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_we    = r_mem_req_we;
    assign mem_req_addr  = r_addr[31:2];
    assign mem_req_wdata = r_wdata;
    assign trace_pc      = r_trace_pc;

endmodule
`default_nettype wire

// File: tb/tb_dm_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_bus_initiator
// Description : Scoreboard bench for dm_bus_initiator with a bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_bus_initiator;

    logic        clk = 1'b0;
    logic        RESET;
    logic        cpu_req, cpu_we;
    logic [2:0]  DMSel;
    logic [31:0] cpu_addr, cpu_wdata, PC;
    logic        stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic [31:0] trace_pc;

    always #5 clk = ~clk;

    dm_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .RESET(RESET), .cpu_req(cpu_req), .cpu_we(cpu_we), .DMSel(DMSel),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .PC(PC), .stall(stall),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .trace_pc(trace_pc)
    );

    typedef struct {
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        chk_pc;
        logic [31:0] pc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    exp_t        mon_e;
    bus_t        rsp_b;
    logic [31:0] mem [int];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          ready_hold = 0;
    bit          rsp_en = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input logic err, input logic cr, input logic [31:0] rd,
                               input logic cp, input logic [31:0] pc, input int lat);
        exp_t e;
        e.err = err; e.chk_rdata = cr; e.rdata = rd; e.chk_pc = cp; e.pc = pc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic expect_bus(input logic we, input logic [29:0] addr, input logic [31:0] wd);
        bus_t b;
        b.we = we; b.addr = addr; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    // Completion monitor: pops one expectation per cpu_done pulse
    always @(negedge clk) begin
        if (!RESET && cpu_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got cpu_done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_err", {31'h0, cpu_err}, {31'h0, mon_e.err});
                if (mon_e.chk_rdata) chk("rdata", cpu_rdata, mon_e.rdata);
                if (mon_e.chk_pc) chk("trace_pc", trace_pc, mon_e.pc);
                chk("latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
            end
        end
    end

    // Bus responder: ready after ready_hold cycles, response one cycle after acceptance
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (pend && rsp_en) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = pend_rdata;
                pend = 1'b0;
            end
            if (mem_req_valid) begin
                if (ready_hold > 0) begin
                    ready_hold--;
                end else begin
                    mem_req_ready = 1'b1;
                    if (bus_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bus: got we=%b addr=%h expected no bus request",
                                 mem_req_we, mem_req_addr);
                    end else begin
                        rsp_b = bus_q.pop_front();
                        chk("bus_we", {31'h0, mem_req_we}, {31'h0, rsp_b.we});
                        chk("bus_addr", {2'b00, mem_req_addr}, {2'b00, rsp_b.addr});
                        if (rsp_b.we) chk("bus_wdata", mem_req_wdata, rsp_b.wdata);
                    end
                    if (mem_req_we) mem[int'(mem_req_addr)] = mem_req_wdata;
                    pend_rdata = mem.exists(int'(mem_req_addr)) ? mem[int'(mem_req_addr)] : 32'h0;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic access(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] pc);
        bit got = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; DMSel = sel; cpu_addr = addr; cpu_wdata = wd; PC = pc;
        start_cyc = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                got = 1'b1;
                break;
            end
            chk("stall_busy", {31'h0, stall}, 32'h1);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no cpu_done expected one within 60 cycles (addr %h)", addr);
        end
        chk("stall_in_done", {31'h0, stall}, 32'h0);
        cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; DMSel = 3'b000;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; PC = 32'h0;
        mem[32'h40]  = 32'h80FF1234;
        mem[32'h80]  = 32'hAABBCCDD;
        mem[32'h04]  = 32'hCAFEF00D;
        mem[32'h100] = 32'h11223344;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_done", {31'h0, cpu_done}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_trace", trace_pc, 32'h0);
        RESET = 1'b0;

        // Loads from word 0x80FF1234
        expect_bus(1'b0, 30'h40, 32'h0); expect_done(1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 32'h0, 3);
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h1000);
        expect_bus(1'b0, 30'h40, 32'h0); expect_done(1'b0, 1'b1, 32'h00000080, 1'b0, 32'h0, 3);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h1004);
        expect_bus(1'b0, 30'h40, 32'h0); expect_done(1'b0, 1'b1, 32'hFFFF80FF, 1'b0, 32'h0, 3);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h1008);
        expect_bus(1'b0, 30'h40, 32'h0); expect_done(1'b0, 1'b1, 32'h000080FF, 1'b0, 32'h0, 3);
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'h100C);
        expect_bus(1'b0, 30'h40, 32'h0); expect_done(1'b0, 1'b1, 32'h80FF1234, 1'b0, 32'h0, 3);
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1010);
        expect_bus(1'b0, 30'h40, 32'h0); expect_done(1'b0, 1'b1, 32'h00000012, 1'b0, 32'h0, 3);
        access(1'b0, 3'b100, 32'h101, 32'h0, 32'h1014);

        // Half store: read-modify-write into the upper lane
        expect_bus(1'b0, 30'h80, 32'h0); expect_bus(1'b1, 30'h80, 32'h1357CCDD);
        expect_done(1'b0, 1'b0, 32'h0, 1'b1, 32'h2000, 5);
        access(1'b1, 3'b001, 32'h202, 32'h00001357, 32'h2000);

        // Word store under 5 cycles of back-pressure
        ready_hold = 5;
        expect_bus(1'b1, 30'hC0, 32'h12345678);
        expect_done(1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 8);
        access(1'b1, 3'b010, 32'h300, 32'h12345678, 32'h3000);

        // Misaligned word and half
        expect_done(1'b1, 1'b0, 32'h0, 1'b1, 32'h3000, 1);
        access(1'b0, 3'b010, 32'h2, 32'h0, 32'h4000);
        expect_done(1'b1, 1'b0, 32'h0, 1'b1, 32'h3000, 1);
        access(1'b0, 3'b001, 32'h1, 32'h0, 32'h4004);

        // Unanswered read times out after 4 wait cycles; late response lands in IDLE
        rsp_en = 1'b0;
        expect_bus(1'b0, 30'h04, 32'h0); expect_done(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6);
        access(1'b0, 3'b010, 32'h10, 32'h0, 32'h4100);
        rsp_en = 1'b1;
        repeat (3) @(negedge clk);
        expect_bus(1'b0, 30'h04, 32'h0); expect_done(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h3000, 3);
        access(1'b0, 3'b010, 32'h10, 32'h0, 32'h4104);

        // Reset while a byte store waits for its read
        rsp_en = 1'b0;
        expect_bus(1'b0, 30'h100, 32'h0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; DMSel = 3'b000; cpu_addr = 32'h401;
        cpu_wdata = 32'h000000A5; PC = 32'h5000;
        repeat (3) @(negedge clk);
        RESET = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("mid_rst_done", {31'h0, cpu_done}, 32'h0);
        chk("mid_rst_stall", {31'h0, stall}, 32'h0);
        chk("mid_rst_we", {31'h0, mem_req_we}, 32'h0);
        chk("mid_rst_addr", {2'b00, mem_req_addr}, 32'h0);
        chk("mid_rst_trace", trace_pc, 32'h0);
        RESET = 1'b0;
        rsp_en = 1'b1;
        repeat (3) @(negedge clk);
        expect_bus(1'b0, 30'h100, 32'h0); expect_bus(1'b1, 30'h100, 32'h1122A544);
        expect_done(1'b0, 1'b0, 32'h0, 1'b1, 32'h5000, 5);
        access(1'b1, 3'b000, 32'h401, 32'h000000A5, 32'h5000);

        repeat (5) @(negedge clk);
        chk("done_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_bus_initiator.md
Name: dm_bus_initiator

Overview:
- CPU-side initiator for the data-memory path. Takes one load/store per request from the M stage and runs it over a word-only, valid/ready memory bus.
- Partial stores (sb/sh) become read-modify-write. Partial loads get lane extraction and sign/zero extension.
- Holds the pipeline via stall until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for mem_rsp_valid in either wait state before aborting with an error. Must be at least 1.

Ports:
- clk  in  1  clock
- RESET  in  1  synchronous active-high reset
- cpu_req  in  1  access request; held high with stable fields until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- DMSel  in  3  [1:0]: 00 byte, 01 half, 1x word; [2]: 1 = zero-extend load, 0 = sign-extend load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data; byte store uses [7:0], half store uses [15:0]
- PC  in  32  instruction PC, carried for trace
- stall  out  1  high while a request is accepted and not yet done
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_done; 1 = misaligned or timeout
- cpu_rdata  out  32  extended load result; valid with cpu_done, held until the next acceptance
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts the request
- mem_req_we  out  1  bus write
- mem_req_addr  out  30  word address, cpu_addr[31:2]
- mem_req_wdata  out  32  full word to write
- mem_rsp_valid  in  1  response; acknowledges a write or returns read data
- mem_rsp_rdata  in  32  read word
- trace_pc  out  32  PC of the last completed store, updated with cpu_done

Behaviour:
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- Misaligned condition: half access with addr[0] = 1, or word access with addr[1:0] != 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE, on cpu_req: latch we, DMSel, addr, wdata, PC.
  - misaligned -> DONE with err = 1; no bus traffic.
  - word store -> WR_REQ with wdata unchanged.
  - otherwise -> RD_REQ.
- RD_REQ / WR_REQ: mem_req_valid = 1, fields stable. When mem_req_ready = 1, advance to RD_WAIT / WR_WAIT. The request may be accepted in the same cycle it is first raised.
- RD_WAIT, on mem_rsp_valid:
  - load: lane-extract and extend into rdata, go to DONE.
  - partial store: merge new byte/half into mem_rsp_rdata at lane addr[1:0] (half lane from addr[1]), go to WR_REQ.
- WR_WAIT: mem_rsp_valid -> DONE; store also updates trace_pc.
- DONE: cpu_done = 1 for exactly one cycle, then IDLE. cpu_req is not sampled in DONE, so a back-to-back request is accepted on the following cycle.
- stall = (cpu_req & state == IDLE) | (state not in {IDLE, DONE}). It is combinational, so stall rises in the request cycle and is low during DONE.
- Timeout counter:
  - Cleared on entry to RD_WAIT or WR_WAIT; increments each waiting cycle.
  - Reaching TIMEOUT_CYCLES without mem_rsp_valid -> DONE with err = 1; mem_req_valid stays low.
  - Not counted in the REQ states; ready back-pressure may last indefinitely.
- A response in the same cycle the counter hits the limit takes priority (success).
- mem_rsp_valid outside RD_WAIT / WR_WAIT is ignored.
- Latency with ready and rsp each 1 cycle after valid:
  - load or word store: 4 cycles from request to done.
  - partial store: 6 cycles.
- Reset mid-transaction: next cycle is IDLE, mem_req_valid = 0, no cpu_done. Late responses are dropped.

Decomposition:
- Shared package dm_pkg holds:
  - DMSel encodings: SEL_BYTE = 2'b00, SEL_HALF = 2'b01, SEL_WORD = 2'b10, and the EXT_ZERO bit.
  - State enum.
  - Misalignment check function.
- One combinational sub-module, dm_lane_unit:
  - inputs word, addr[1:0], DMSel, wdata;
  - outputs extended load value and merged store word.

Test Plan:
- Load byte: mem word 0x80FF1234, cpu_addr 0x103, DMSel 000 -> rdata 0xFFFFFF80; DMSel 100 -> 0x00000080; one bus read to word 0x40.
- Store half: mem 0xAABBCCDD, cpu_addr 0x202, wdata 0x00001357 -> read, then write 0x1357CCDD; cpu_done after the write ack; trace_pc = PC.
- Store word with mem_req_ready held low 5 cycles -> stall high throughout; exactly one write with 0x12345678; no timeout.
- Misaligned: lw at 0x2 or lh at 0x1 -> cpu_done with cpu_err = 1 two cycles after the request; mem_req_valid never asserted.
- TIMEOUT_CYCLES = 4, read never answered -> cpu_err = 1 after 4 wait cycles. A late rsp in IDLE is ignored; a following lw completes normally.
- RESET asserted in RD_WAIT of a sb -> no write issued, no cpu_done, outputs 0. The next request runs cleanly.
